// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// the sizing rule for the bus-timeout counter.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wide enough to hold the value MAX_WAIT itself.
    function automatic int wait_cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port; the stage is master, memory is slave.
// Single outstanding request, completed by a one-cycle DMemAck pulse.
interface mem_access_stage_if;

    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [3:0]  DMemByteEn;
    logic [31:0] DMemWData;
    logic [31:0] DMemRData;
    logic        DMemAck;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemByteEn, DMemWData,
        input  DMemRData, DMemAck
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemByteEn, DMemWData,
        output DMemRData, DMemAck
    );

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
// Purely combinational; no state, no backpressure.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_RData,
    input  logic [1:0]  i_Addr,
    input  logic [1:0]  i_Size,
    input  logic        i_Signed,
    output logic [31:0] o_Data
);

    logic [7:0]  w_Byte;
    logic [15:0] w_Half;

    always_comb begin
        w_Byte = i_RData[7:0];
        case (i_Addr)
            2'd0:    w_Byte = i_RData[7:0];
            2'd1:    w_Byte = i_RData[15:8];
            2'd2:    w_Byte = i_RData[23:16];
            default: w_Byte = i_RData[31:24];
        endcase
    end

    // Half lane ignores addr[0]; misaligned halves are trapped upstream when checked.
    assign w_Half = i_Addr[1] ? i_RData[31:16] : i_RData[15:0];

    always_comb begin
        o_Data = i_RData;
        case (i_Size)
            SIZE_BYTE: o_Data = {{24{i_Signed & w_Byte[7]}}, w_Byte};
            SIZE_HALF: o_Data = {{16{i_Signed & w_Half[15]}}, w_Half};
            default:   o_Data = i_RData;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM load/store control into one DMem transaction (>=3 cycles),
// holding Stall until done; DMemAck timeout -> BusError. MEM_ALIGN_CHECK_EN traps misaligned accesses.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       MemRead_In,
    input  logic                       MemWrite_In,
    input  logic [1:0]                 MemSize_In,
    input  logic                       LoadSigned_In,
    input  logic [31:0]                Address_In,
    input  logic [31:0]                WriteData_In,
    mem_access_stage_if.master         dmem,
    output logic [31:0]                ReadData_Out,
    output logic                       Stall,
    output logic                       BusError,
    output logic                       Misaligned
);

    localparam int CNT_W = wait_cnt_w(MAX_WAIT);

    state_t             r_State;
    state_t             w_NextState;
    logic [CNT_W-1:0]   r_WaitCnt;
    logic               r_DMemReq;
    logic               r_DMemWe;
    logic [31:0]        r_DMemAddr;
    logic [3:0]         r_DMemByteEn;
    logic [31:0]        r_DMemWData;
    logic [31:0]        r_ReadData;
    logic               r_BusError;

    logic               w_Req;
    logic               w_Timeout;
    logic               w_Misalign;
    logic [3:0]         w_StoreBe;
    logic [31:0]        w_StoreWd;
    logic [31:0]        w_LoadVal;

    assign w_Req     = MemRead_In | MemWrite_In;
    assign w_Timeout = (r_WaitCnt == CNT_W'(MAX_WAIT));

`ifdef MEM_ALIGN_CHECK_EN
    logic r_Misaligned;

    assign w_Misalign = ((MemSize_In == SIZE_HALF) && Address_In[0]) ||
                        (((MemSize_In == SIZE_WORD) || (MemSize_In == SIZE_RSVD)) &&
                         (Address_In[1:0] != 2'b00));
    assign Misaligned = r_Misaligned;
`else
    assign w_Misalign = 1'b0;
    assign Misaligned = 1'b0;
`endif

    always_comb begin
        w_StoreBe = 4'b1111;
        w_StoreWd = WriteData_In;
        case (MemSize_In)
            SIZE_BYTE: begin
                w_StoreBe = 4'b0001 << Address_In[1:0];
                w_StoreWd = {4{WriteData_In[7:0]}};
            end
            SIZE_HALF: begin
                w_StoreBe = Address_In[1] ? 4'b1100 : 4'b0011;
                w_StoreWd = {2{WriteData_In[15:0]}};
            end
            default: begin
                w_StoreBe = 4'b1111;
                w_StoreWd = WriteData_In;
            end
        endcase
    end

    mem_load_align u_load_align (
        .i_RData  (dmem.DMemRData),
        .i_Addr   (Address_In[1:0]),
        .i_Size   (MemSize_In),
        .i_Signed (LoadSigned_In),
        .o_Data   (w_LoadVal)
    );

    always_ff @(posedge Clock) begin
        if (Reset) r_State <= ST_IDLE;
        else       r_State <= w_NextState;
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            ST_IDLE: if (w_Req) w_NextState = w_Misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem.DMemAck || w_Timeout) w_NextState = ST_DONE;
            ST_DONE: w_NextState = ST_IDLE;
            default: w_NextState = ST_IDLE;
        endcase
    end

    // Low in DONE so MEM/WB captures ReadData_Out on the DONE->IDLE edge.
    always_comb begin
        Stall = 1'b0;
        if (!Reset)
            Stall = ((r_State == ST_IDLE) && w_Req) || (r_State == ST_REQ);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_WaitCnt    <= '0;
            r_DMemReq    <= 1'b0;
            r_DMemWe     <= 1'b0;
            r_DMemAddr   <= '0;
            r_DMemByteEn <= '0;
            r_DMemWData  <= '0;
            r_ReadData   <= '0;
            r_BusError   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_Misaligned <= 1'b0;
`endif
        end else begin
            r_BusError <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_Misaligned <= 1'b0;
`endif
            case (r_State)
                ST_IDLE: begin
                    if (w_Req && !w_Misalign) begin
                        r_DMemReq    <= 1'b1;
                        r_DMemWe     <= MemWrite_In;
                        r_DMemAddr   <= {Address_In[31:2], 2'b00};
                        r_DMemByteEn <= MemWrite_In ? w_StoreBe : 4'b1111;
                        r_DMemWData  <= w_StoreWd;
                        r_WaitCnt    <= CNT_W'(1);
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (w_Req && w_Misalign) begin
                        r_ReadData   <= '0;
                        r_Misaligned <= 1'b1;
                    end
`endif
                end
                ST_REQ: begin
                    if (dmem.DMemAck || w_Timeout) begin
                        r_DMemReq    <= 1'b0;
                        r_DMemWe     <= 1'b0;
                        r_DMemAddr   <= '0;
                        r_DMemByteEn <= '0;
                        r_DMemWData  <= '0;
                        r_WaitCnt    <= '0;
                        // An ack in the final allowed cycle still counts as success.
                        if (dmem.DMemAck) begin
                            if (!r_DMemWe) r_ReadData <= w_LoadVal;
                        end else begin
                            r_ReadData <= '0;
                            r_BusError <= 1'b1;
                        end
                    end else begin
                        r_WaitCnt <= r_WaitCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.DMemReq    = r_DMemReq;
    assign dmem.DMemWe     = r_DMemWe;
    assign dmem.DMemAddr   = r_DMemAddr;
    assign dmem.DMemByteEn = r_DMemByteEn;
    assign dmem.DMemWData  = r_DMemWData;
    assign ReadData_Out    = r_ReadData;
    assign BusError        = r_BusError;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: loads/stores of each size, delayed ack,
// timeout, write-over-read priority, stray ack, reset mid-request, alignment.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int MAX_WAIT = 15;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        MemRead_In = 1'b0;
    logic        MemWrite_In = 1'b0;
    logic [1:0]  MemSize_In = 2'b00;
    logic        LoadSigned_In = 1'b0;
    logic [31:0] Address_In = '0;
    logic [31:0] WriteData_In = '0;
    logic [31:0] ReadData_Out;
    logic        Stall;
    logic        BusError;
    logic        Misaligned;

    mem_access_stage_if dmem();

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .MemRead_In    (MemRead_In),
        .MemWrite_In   (MemWrite_In),
        .MemSize_In    (MemSize_In),
        .LoadSigned_In (LoadSigned_In),
        .Address_In    (Address_In),
        .WriteData_In  (WriteData_In),
        .dmem          (dmem),
        .ReadData_Out  (ReadData_Out),
        .Stall         (Stall),
        .BusError      (BusError),
        .Misaligned    (Misaligned)
    );

    always #5 Clock = ~Clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sgn,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> (8 * a[1:0]));
        h = 16'(rd >> (a[1] ? 16 : 0));
        if (sz == SIZE_BYTE) return sgn ? 32'($signed(b)) : 32'(b);
        if (sz == SIZE_HALF) return sgn ? 32'($signed(h)) : 32'(h);
        return rd;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == SIZE_BYTE) return 4'(1 << a[1:0]);
        if (sz == SIZE_HALF) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == SIZE_BYTE) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (sz == SIZE_HALF) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if (sz == SIZE_HALF) return a[0];
        if (sz != SIZE_BYTE) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // ack_at = REQ cycle in which the memory acks; 0 means never (timeout).
    task automatic access(input string tag, input bit rd, input bit wr,
                          input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdata, input int ack_at);
        bit          mis;
        bit          to;
        bit          done;
        int          stalls;
        int          reqs;
        logic [31:0] exp_rd;
        mis    = model_mis(sz, a);
        to     = !mis && (ack_at == 0);
        done   = 1'b0;
        stalls = 0;
        reqs   = 0;
        exp_rd = (mis || to) ? 32'h0 : (wr ? last_rd : model_load(sz, sgn, a, rdata));
        exp_q.push_back(exp_rd);
        last_rd = exp_rd;

        @(negedge Clock);
        MemRead_In = rd; MemWrite_In = wr; MemSize_In = sz;
        LoadSigned_In = sgn; Address_In = a; WriteData_In = wd;
        #1;
        for (int c = 0; c < MAX_WAIT + 20; c++) begin
            if (!Stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (dmem.DMemReq) begin
                reqs++;
                chk({tag, "_addr"}, dmem.DMemAddr, {a[31:2], 2'b00});
                if (reqs == 1) begin
                    chk({tag, "_we"}, 32'(dmem.DMemWe), 32'(wr));
                    chk({tag, "_be"}, 32'(dmem.DMemByteEn), wr ? 32'(model_be(sz, a)) : 32'hF);
                    if (wr) chk({tag, "_wdata"}, dmem.DMemWData, model_wd(sz, wd));
                end
                if (reqs == ack_at) begin
                    dmem.DMemAck   = 1'b1;
                    dmem.DMemRData = rdata;
                end
            end
            @(posedge Clock);
            #1;
            dmem.DMemAck   = 1'b0;
            dmem.DMemRData = $urandom;
            @(negedge Clock);
            #1;
        end
        chk({tag, "_reached_done"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, stalls, mis ? 1 : (to ? MAX_WAIT + 1 : ack_at + 1));
        chk({tag, "_req_cycles"}, reqs, mis ? 0 : (to ? MAX_WAIT : ack_at));
        chk({tag, "_req_dropped"}, 32'(dmem.DMemReq), 32'd0);
        chk({tag, "_buserror"}, 32'(BusError), 32'(to));
        chk({tag, "_misaligned"}, 32'(Misaligned), 32'(mis));
        chk({tag, "_rdata"}, ReadData_Out, exp_q.pop_front());

        MemRead_In = 1'b0; MemWrite_In = 1'b0;
        @(negedge Clock);
        #1;
        chk({tag, "_flags_cleared"}, {30'd0, BusError, Misaligned}, 32'd0);
        chk({tag, "_rdata_hold"}, ReadData_Out, last_rd);
    endtask

    initial begin
        dmem.DMemAck   = 1'b0;
        dmem.DMemRData = '0;

        // Request asserted during reset must not raise Stall.
        MemRead_In = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1;
        chk("reset_stall", 32'(Stall), 32'd0);
        chk("reset_outs", {27'd0, dmem.DMemReq, dmem.DMemWe, BusError, Misaligned, 1'b0}, 32'd0);
        chk("reset_addr", dmem.DMemAddr, 32'd0);
        chk("reset_be_wd", dmem.DMemWData | 32'(dmem.DMemByteEn), 32'd0);
        chk("reset_rdata", ReadData_Out, 32'd0);
        MemRead_In = 1'b0;
        Reset = 1'b0;

        access("lb_signed",  1, 0, SIZE_BYTE, 1, 32'h103, 32'h0, 32'h80FF1234, 1);
        access("sh_store",   0, 1, SIZE_HALF, 0, 32'h202, 32'h0000BEEF, 32'h0, 1);
        access("lw_delayed", 1, 0, SIZE_WORD, 0, 32'h40,  32'h0, 32'hDEADBEEF, 3);
        access("lbu",        1, 0, SIZE_BYTE, 0, 32'h101, 32'h0, 32'h1234ABCD, 1);
        access("lh_signed",  1, 0, SIZE_HALF, 1, 32'h102, 32'h0, 32'h80017FFF, 2);
        access("lhu",        1, 0, SIZE_HALF, 0, 32'h100, 32'h0, 32'h1234F00D, 1);
        access("sb_store",   0, 1, SIZE_BYTE, 0, 32'h301, 32'hFFFFFF5A, 32'h0, 2);
        access("sw_store",   0, 1, SIZE_WORD, 0, 32'h400, 32'h01234567, 32'h0, 1);
        access("rw_both",    1, 1, SIZE_BYTE, 0, 32'h502, 32'h000000C3, 32'h0, 1);
        access("lw_rsvd",    1, 0, SIZE_RSVD, 0, 32'h44,  32'h0, 32'hCAFEF00D, 1);
        access("lw_timeout", 1, 0, SIZE_WORD, 0, 32'h80,  32'h0, 32'h0, 0);
        access("lw_at_max",  1, 0, SIZE_WORD, 0, 32'h84,  32'h0, 32'h13579BDF, MAX_WAIT);
        access("lw_mis",     1, 0, SIZE_WORD, 0, 32'h102, 32'h0, 32'h2468ACE0, 1);
        access("sh_mis",     0, 1, SIZE_HALF, 0, 32'h203, 32'h00001111, 32'h0, 1);

        // Stray ack while idle must not touch the load result.
        @(negedge Clock);
        dmem.DMemAck = 1'b1; dmem.DMemRData = 32'hFFFFFFFF;
        @(posedge Clock);
        #1;
        dmem.DMemAck = 1'b0;
        @(negedge Clock);
        #1;
        chk("stray_ack_rdata", ReadData_Out, last_rd);
        chk("stray_ack_req", 32'(dmem.DMemReq), 32'd0);

        // Reset asserted in REQ cycle 2, ack arrives the cycle after.
        @(negedge Clock);
        MemRead_In = 1'b1; MemSize_In = SIZE_WORD; Address_In = 32'h600;
        @(negedge Clock);
        @(negedge Clock);
        #1;
        chk("rst_mid_req_active", 32'(dmem.DMemReq), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        @(negedge Clock);
        #1;
        chk("rst_mid_req_drop", 32'(dmem.DMemReq), 32'd0);
        chk("rst_mid_addr", dmem.DMemAddr, 32'd0);
        chk("rst_mid_rdata", ReadData_Out, 32'd0);
        Reset = 1'b0; MemRead_In = 1'b0;
        dmem.DMemAck = 1'b1; dmem.DMemRData = 32'h55AA55AA;
        @(posedge Clock);
        #1;
        dmem.DMemAck = 1'b0;
        @(negedge Clock);
        #1;
        chk("late_ack_rdata", ReadData_Out, 32'd0);
        chk("late_ack_flags", {29'd0, dmem.DMemReq, BusError, Stall}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage pipeline, between EX/MEM and MEM/WB. It turns the load or store control from EX/MEM into a request/acknowledge transaction on the data-memory port and handles byte, half and word lanes. It sign- or zero-extends load data into `ReadData_Out`, which MEM/WB captures as its read-data input. While a transaction is outstanding it holds `Stall` high, which freezes the upstream pipeline registers and gates MEM/WB `WriteEnable`.

## Interface
- `MAX_WAIT`, default 15: memory REQ cycles allowed before bus-error timeout (legal range 1–255).
- `Clock` in 1: clock.
- `Reset` in 1: reset, synchronous, active-high.
- `MemRead_In` in 1: load request from EX/MEM.
- `MemWrite_In` in 1: store request from EX/MEM. Wins if asserted together with `MemRead_In`.
- `MemSize_In` in 2: access size. 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- `LoadSigned_In` in 1: 1 sign-extends sub-word loads, 0 zero-extends.
- `Address_In` in 32: byte address (ALU result).
- `WriteData_In` in 32: store data, right-aligned.
- `DMemReq` out 1: request valid.
- `DMemWe` out 1: 1 write, 0 read.
- `DMemAddr` out 32: word address, `{Address_In[31:2],2'b00}`.
- `DMemByteEn` out 4: byte-lane enables, little-endian.
- `DMemWData` out 32: lane-replicated store data.
- `DMemRData` in 32: read data, valid in the ack cycle.
- `DMemAck` in 1: single-cycle completion pulse.
- `ReadData_Out` out 32: formatted load result, registered.
- `Stall` out 1: pipeline hold.
- `BusError` out 1: one-cycle timeout flag.
- `Misaligned` out 1: one-cycle alignment-fault flag. Tied to 0 without the macro.

## Operation
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ when a read or write request is present. `DMemReq`, `DMemWe`, `DMemAddr`, `DMemByteEn` and `DMemWData` are registered on this edge.
  - REQ → DONE on `DMemAck`, or on timeout.
  - DONE → IDLE unconditionally. No new request is accepted in DONE, because the inputs still belong to the completed instruction.
- Store lanes:
  - Byte: `ByteEn = 1<<addr[1:0]`, `WData = {4{wd[7:0]}}`.
  - Half: `ByteEn = addr[1] ? 1100 : 0011`, `WData = {2{wd[15:0]}}`.
  - Word: `ByteEn = 1111`, `WData = wd`.
- Loads issue `ByteEn = 1111`. On ack, the selected lane (shift by `addr[1:0]*8`) is extended to 32 bits per `LoadSigned_In` and registered into `ReadData_Out`.
- Stores leave `ReadData_Out` unchanged.
- Timeout: the wait counter counts REQ cycles. If no ack has arrived by the end of REQ cycle `MAX_WAIT`:
  - drop `DMemReq`;
  - `ReadData_Out` ← 0;
  - pulse `BusError` in DONE.
- `DMemAck` is ignored outside REQ, so stray or late acks have no effect.
- Reset values: state IDLE, counter 0, and every output 0. This includes `DMemReq`, `DMemWe`, `DMemAddr`, `DMemByteEn`, `DMemWData`, `ReadData_Out`, `BusError` and `Misaligned`. `Stall` is 0 while `Reset` is high.
- Reset during REQ: `DMemReq` falls at that edge and the transaction is abandoned. Any later ack is ignored.

## Timing
- `Stall` is combinational: `(IDLE && (MemRead_In||MemWrite_In)) || REQ`. It is low in DONE, so MEM/WB captures `ReadData_Out` on the DONE→IDLE edge.
- Minimum access is 3 cycles (IDLE detect, REQ with same-cycle ack, DONE). An ack in REQ cycle N gives `Stall` high for N+1 cycles.
- `DMem*` outputs are stable for the whole of REQ.
- `ReadData_Out` is valid from DONE onward and holds until the next load completes.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, skips REQ (IDLE→DONE directly).
  - No memory request is issued and stores are suppressed.
  - `ReadData_Out` ← 0 and `Misaligned` pulses in DONE.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
  - `Misaligned` is constant 0.

## Structure
- Shared package `mem_stage_pkg` holds:
  - the `MemSize` encodings (`SIZE_WORD`, `SIZE_HALF`, `SIZE_BYTE`);
  - the FSM state constants;
  - the timeout counter width, `$clog2(MAX_WAIT+1)`.
- One combinational sub-module, `mem_load_align`: inputs `RData`, `addr[1:0]`, `size`, `signed`; output is the 32-bit extended load value.
- Store-lane generation stays inline.

## Test plan
- Signed byte load: LB at 0x103, signed, `RData=0x80FF1234`, ack in the first REQ cycle → `DMemAddr=0x100`, `ReadData_Out=0xFFFFFF80`, `Stall` high 2 cycles.
- Half store: SH at 0x202, data 0x0000BEEF → `DMemAddr=0x200`, `ByteEn=1100`, `WData=0xBEEFBEEF`, `DMemWe=1`.
- Delayed ack: LW at 0x40, ack in REQ cycle 3, `RData=0xDEADBEEF` → `Stall` high 4 cycles, then `ReadData_Out=0xDEADBEEF` in DONE.
- Timeout: LW with no ack, `MAX_WAIT=15` → `DMemReq` high 15 cycles, then `BusError` pulses once and `ReadData_Out=0`.
- Reset mid-REQ: `Reset` in REQ cycle 2, ack in the cycle after → all outputs 0, state IDLE, ack ignored.
- Misaligned word (with `MEM_ALIGN_CHECK_EN`): LW at 0x102 → no `DMemReq`, `Misaligned` pulse, `ReadData_Out=0`, `Stall` high 1 cycle.
